// File: rtl/jc_pkg.sv
// jc_pkg
// Shared definitions for the Johnson-sequenced slot scheduler:
//   - the eight legal 4-bit Johnson slot codes
//   - slot index enum and FSM state enum
//   - helpers: legality check, code -> slot index decode, code successor
`timescale 1ns/1ps
package jc_pkg;

  localparam logic [3:0] JC_S0 = 4'b0000;
  localparam logic [3:0] JC_S1 = 4'b1000;
  localparam logic [3:0] JC_S2 = 4'b1100;
  localparam logic [3:0] JC_S3 = 4'b1110;
  localparam logic [3:0] JC_S4 = 4'b1111;
  localparam logic [3:0] JC_S5 = 4'b0111;
  localparam logic [3:0] JC_S6 = 4'b0011;
  localparam logic [3:0] JC_S7 = 4'b0001;

  typedef enum logic [2:0] {
    SLOT_0, SLOT_1, SLOT_2, SLOT_3, SLOT_4, SLOT_5, SLOT_6, SLOT_7
  } slot_e;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    GRANT
  } state_e;

  function automatic logic jc_is_legal(input logic [3:0] code);
    logic ok;
    ok = 1'b0;
    case (code)
      JC_S0, JC_S1, JC_S2, JC_S3, JC_S4, JC_S5, JC_S6, JC_S7: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Illegal codes decode to slot 0; callers gate on legality separately.
  function automatic slot_e jc_decode(input logic [3:0] code);
    slot_e idx;
    idx = SLOT_0;
    case (code)
      JC_S1:   idx = SLOT_1;
      JC_S2:   idx = SLOT_2;
      JC_S3:   idx = SLOT_3;
      JC_S4:   idx = SLOT_4;
      JC_S5:   idx = SLOT_5;
      JC_S6:   idx = SLOT_6;
      JC_S7:   idx = SLOT_7;
      default: idx = SLOT_0;
    endcase
    return idx;
  endfunction

  // Johnson successor: shift right, feeding the inverted LSB into the MSB.
  // 0001 -> 0000 falls out naturally, closing the 8-state ring.
  function automatic logic [3:0] jc_next(input logic [3:0] code);
    return {~code[0], code[3:1]};
  endfunction

endpackage

// File: rtl/johnson_step.sv
// johnson_step
// 4-bit Johnson slot register. Advances one step per cycle when 'advance'
// is high and self-recovers to 0000 on the edge after an illegal code.
// Ports:
//   CLK     in  system clock
//   CLR     in  synchronous active-high reset (code -> 0000)
//   advance in  step to the Johnson successor on the next edge
//   code    out current 4-bit Johnson code (registered)
//   legal   out high when code is one of the eight legal codes
`timescale 1ns/1ps
module johnson_step
  import jc_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic       advance,
  output logic [3:0] code,
  output logic       legal
);

  logic [3:0] code_reg;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      code_reg <= JC_S0;
    end else if (!legal) begin
      code_reg <= JC_S0;
    end else if (advance) begin
      code_reg <= jc_next(code_reg);
    end
  end

  assign code  = code_reg;
  assign legal = jc_is_legal(code_reg);

endmodule

// File: rtl/johnson_slot_scheduler.sv
// johnson_slot_scheduler
// Time-division slot scheduler for up to eight requesters. A Johnson ring
// selects the candidate slot; the owner is granted for up to SLOT_LEN
// cycles when requesting, idle slots are skipped one per cycle.
// Parameters:
//   SLOT_LEN  maximum grant dwell in cycles (1..16)
// Ports:
//   CLK      in   system clock
//   CLR      in   synchronous active-high reset
//   EN       in   scheduler enable
//   REQ[7:0] in   per-slot requests
//   DONE     in   early release from the current grantee
//   GNT[7:0] out  one-hot registered grant
//   SLOT     out  current Johnson slot code
//   SLOT_IDX out  binary index of SLOT (registered)
//   BUSY     out  high in SCAN or GRANT
//   ERR      out  one-cycle pulse after an illegal slot code
`timescale 1ns/1ps
module johnson_slot_scheduler
  import jc_pkg::*;
#(
  parameter int SLOT_LEN = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       EN,
  input  logic [7:0] REQ,
  input  logic       DONE,
  output logic [7:0] GNT,
  output logic [3:0] SLOT,
  output logic [2:0] SLOT_IDX,
  output logic       BUSY,
  output logic       ERR
);

  localparam logic [4:0] DWELL_LOAD = 5'(SLOT_LEN - 1);

  state_e     state_reg,    state_next;
  logic [4:0] dwell_reg,    dwell_next;
  logic [7:0] gnt_reg,      gnt_next;
  slot_e      slot_idx_reg, slot_idx_next;
  logic       busy_reg;
  logic       err_reg;

  logic       advance;
  logic [3:0] code;
  logic       legal;
  logic [3:0] code_next;
  logic       release_now;

  johnson_step u_step (
    .CLK     (CLK),
    .CLR     (CLR),
    .advance (advance),
    .code    (code),
    .legal   (legal)
  );

  // Grant ends on the cycle any release condition is sampled; that cycle
  // is the last one with GNT high.
  assign release_now = (dwell_reg == 5'd0) || DONE || !REQ[slot_idx_reg] || !EN;

  always_comb begin
    state_next = state_reg;
    dwell_next = dwell_reg;
    gnt_next   = gnt_reg;
    advance    = 1'b0;

    case (state_reg)
      IDLE: begin
        gnt_next = 8'h00;
        if (EN && (|REQ)) begin
          state_next = SCAN;
        end
      end

      SCAN: begin
        gnt_next = 8'h00;
        if (!EN || (REQ == 8'h00)) begin
          state_next = IDLE;
        end else if (REQ[slot_idx_reg]) begin
          state_next = GRANT;
          gnt_next   = 8'(1) << slot_idx_reg;
          dwell_next = DWELL_LOAD;
        end else begin
          advance = 1'b1;
        end
      end

      GRANT: begin
        if (release_now) begin
          // Always move on to the next slot so a still-requesting owner
          // cannot be re-granted ahead of other waiting slots.
          gnt_next   = 8'h00;
          advance    = 1'b1;
          state_next = EN ? SCAN : IDLE;
        end else begin
          dwell_next = dwell_reg - 5'd1;
        end
      end

      default: begin
        state_next = IDLE;
        gnt_next   = 8'h00;
      end
    endcase

    // A corrupted slot code overrides everything; the Johnson register
    // recovers to 0000 on the same edge.
    if (!legal) begin
      state_next = IDLE;
      gnt_next   = 8'h00;
      dwell_next = 5'd0;
      advance    = 1'b0;
    end
  end

  // Mirror of the Johnson register's next value so SLOT_IDX updates on the
  // same edge as SLOT.
  always_comb begin
    code_next = code;
    if (!legal) begin
      code_next = JC_S0;
    end else if (advance) begin
      code_next = jc_next(code);
    end
    slot_idx_next = jc_decode(code_next);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg    <= IDLE;
      dwell_reg    <= 5'd0;
      gnt_reg      <= 8'h00;
      slot_idx_reg <= SLOT_0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      dwell_reg    <= dwell_next;
      gnt_reg      <= gnt_next;
      slot_idx_reg <= slot_idx_next;
      busy_reg     <= (state_next != IDLE);
      err_reg      <= !legal;
    end
  end

  assign GNT      = gnt_reg;
  assign SLOT     = code;
  assign SLOT_IDX = slot_idx_reg;
  assign BUSY     = busy_reg;
  assign ERR      = err_reg;

endmodule
